// File: rtl/idct8_pkg.sv
// Shared constants, fixed-point helpers and FSM encoding for the 8-point Chen IDCT.
package idct8_pkg;

    typedef enum logic [2:0] {S_IDLE, P0, P1, P2, P3, S_WAIT} state_t;

    // Q1.15 cosine constants; narrower builds shift these right.
    localparam int H1 = 16069;
    localparam int H2 = 15137;
    localparam int H3 = 13623;
    localparam int H4 = 11585;
    localparam int H5 = 9102;
    localparam int H6 = 6270;
    localparam int H7 = 3196;

    localparam int H_Q15 [8] = '{0, H1, H2, H3, H4, H5, H6, H7};

    // Odd-part product slot = {row i, column k}; column k multiplies X(2k+1).
    localparam logic [2:0] ODD_H [16] = '{
        3'd1, 3'd3, 3'd5, 3'd7,
        3'd3, 3'd7, 3'd1, 3'd5,
        3'd5, 3'd1, 3'd7, 3'd3,
        3'd7, 3'd5, 3'd3, 3'd1
    };
    localparam logic [15:0] ODD_NEG = 16'hA2E0;

    function automatic int frac_of(input int const_w);
        return const_w - 1;
    endfunction

    function automatic int h_coef(input logic [2:0] idx, input int const_w);
        return H_Q15[idx] >>> (16 - const_w);
    endfunction

endpackage

// File: rtl/lut_multiplier.sv
// Signed constant multiplier built from fabric logic: o_p = (i_a * i_c) >>> FRAC, truncated.
module lut_multiplier #(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16,
    parameter int FRAC    = 15
) (
    input  logic signed [IN_W-1:0]    i_a,
    input  logic signed [CONST_W-1:0] i_c,
    output logic signed [IN_W-1:0]    o_p
);

    localparam int P_W = IN_W + CONST_W;

    (* use_dsp = "no" *) logic signed [P_W-1:0] w_full;

    assign w_full = P_W'(i_a) * P_W'(i_c);
    assign o_p    = IN_W'(w_full >>> FRAC);

endmodule

// File: rtl/idct8_chen_ts.sv
// Time-shared 8-point Chen IDCT: 22 products on NUM_MUL=8 multipliers over P0..P2, butterfly in P3.
// Define IDCT8_OUT_SAT_EN to clamp outputs to SAT_W bits.
module idct8_chen_ts
    import idct8_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int CONST_W = 16,
    parameter int NUM_MUL = 8,
    parameter int SAT_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7
);

    typedef logic signed [IN_W-1:0] data_t;

    localparam int FRAC = frac_of(CONST_W);

`ifdef IDCT8_OUT_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam data_t SAT_MAX = IN_W'((64'sd1 <<< (SAT_W - 1)) - 64'sd1);
    localparam data_t SAT_MIN = IN_W'(-(64'sd1 <<< (SAT_W - 1)));

    state_t r_state;
    logic   r_in_ready;
    logic   r_out_valid;
    data_t  r_out [8];
    data_t  r_x   [8];
    data_t  r_ev  [4];
    data_t  r_odd [4];

    data_t                      w_a [NUM_MUL];
    logic signed [CONST_W-1:0]  w_c [NUM_MUL];
    data_t                      w_p [NUM_MUL];
    logic [3:0]                 w_slot [NUM_MUL];
    logic                       w_slot_vld [NUM_MUL];
    data_t                      w_odd_add [4];
    data_t                      w_e [4];
    data_t                      w_x [8];

    function automatic logic signed [CONST_W-1:0] coef(input logic [2:0] idx);
        return CONST_W'(h_coef(idx, CONST_W));
    endfunction

    function automatic data_t sat_out(input data_t v);
        if (SAT_EN && (v > SAT_MAX)) return SAT_MAX;
        if (SAT_EN && (v < SAT_MIN)) return SAT_MIN;
        return v;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        for (int m = 0; m < NUM_MUL; m++) begin
            w_a[m]        = '0;
            w_c[m]        = '0;
            w_slot[m]     = '0;
            w_slot_vld[m] = 1'b0;
        end
        case (r_state)
            P0: begin
                w_a[0] = r_x[0] + r_x[4];  w_c[0] = coef(3'd4);
                w_a[1] = r_x[0] - r_x[4];  w_c[1] = coef(3'd4);
                w_a[2] = r_x[2];           w_c[2] = coef(3'd2);
                w_a[3] = r_x[6];           w_c[3] = coef(3'd6);
                w_a[4] = r_x[2];           w_c[4] = coef(3'd6);
                w_a[5] = r_x[6];           w_c[5] = coef(3'd2);
                w_slot[6] = 4'd0;  w_slot_vld[6] = 1'b1;
                w_slot[7] = 4'd1;  w_slot_vld[7] = 1'b1;
            end
            P1: begin
                for (int m = 0; m < 8; m++) begin
                    w_slot[m]     = 4'(m + 2);
                    w_slot_vld[m] = 1'b1;
                end
            end
            P2: begin
                for (int m = 0; m < 6; m++) begin
                    w_slot[m]     = 4'(m + 10);
                    w_slot_vld[m] = 1'b1;
                end
            end
            default: ;
        endcase
        for (int m = 0; m < NUM_MUL; m++) begin
            if (w_slot_vld[m]) begin
                w_a[m] = r_x[{w_slot[m][1:0], 1'b1}];
                w_c[m] = coef(ODD_H[w_slot[m]]);
            end
        end
    end

    for (genvar m = 0; m < NUM_MUL; m++) begin : g_mul
        lut_multiplier #(
            .IN_W    (IN_W),
            .CONST_W (CONST_W),
            .FRAC    (FRAC)
        ) u_mul (
            .i_a (w_a[m]),
            .i_c (w_c[m]),
            .o_p (w_p[m])
        );
    end

    // Odd products land in their row accumulator with the row's sign.
    always_comb begin
        for (int i = 0; i < 4; i++) w_odd_add[i] = '0;
        for (int m = 0; m < NUM_MUL; m++) begin
            if (w_slot_vld[m]) begin
                if (ODD_NEG[w_slot[m]]) w_odd_add[w_slot[m][3:2]] -= w_p[m];
                else                    w_odd_add[w_slot[m][3:2]] += w_p[m];
            end
        end
    end

    always_comb begin
        w_e[0] = r_ev[0] + r_ev[2];
        w_e[1] = r_ev[1] + r_ev[3];
        w_e[2] = r_ev[1] - r_ev[3];
        w_e[3] = r_ev[0] - r_ev[2];
        for (int i = 0; i < 4; i++) begin
            w_x[i]     = sat_out(w_e[i] + r_odd[i]);
            w_x[7 - i] = sat_out(w_e[i] - r_odd[i]);
        end
    end

    // NOTE: datapath registers carry no reset; the FSM alone decides when their contents are used.
    always_ff @(posedge clk) begin
        if (r_in_ready && in_valid) begin
            r_x[0] <= in0;  r_x[1] <= in1;  r_x[2] <= in2;  r_x[3] <= in3;
            r_x[4] <= in4;  r_x[5] <= in5;  r_x[6] <= in6;  r_x[7] <= in7;
        end
        case (r_state)
            P0: begin
                r_ev[0] <= w_p[0];
                r_ev[1] <= w_p[1];
                r_ev[2] <= w_p[2] + w_p[3];
                r_ev[3] <= w_p[4] - w_p[5];
                for (int i = 0; i < 4; i++) r_odd[i] <= w_odd_add[i];
            end
            P1, P2: begin
                for (int i = 0; i < 4; i++) r_odd[i] <= r_odd[i] + w_odd_add[i];
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            for (int i = 0; i < 8; i++) r_out[i] <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_state    <= P0;
                    r_in_ready <= 1'b0;
                end
                P0: r_state <= P1;
                P1: r_state <= P2;
                P2: r_state <= P3;
                P3: begin
                    for (int i = 0; i < 8; i++) r_out[i] <= w_x[i];
                    r_out_valid <= 1'b1;
                    r_state     <= S_WAIT;
                end
                S_WAIT: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out0 = r_out[0];
    assign out1 = r_out[1];
    assign out2 = r_out[2];
    assign out3 = r_out[3];
    assign out4 = r_out[4];
    assign out5 = r_out[5];
    assign out6 = r_out[6];
    assign out7 = r_out[7];

endmodule
